// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder over a word-addressed SRAM; independent read and write channels.
// Contents are preloadable through the hierarchical array `mem`.
module axi_lite_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STRB_WIDTH = 4,
    parameter int                    PROT_WIDTH = 3,
    parameter int                    RESP_WIDTH = 2,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [PROT_WIDTH-1:0] s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [RESP_WIDTH-1:0] s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [PROT_WIDTH-1:0] s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [RESP_WIDTH-1:0] s_axi_rresp
);
    localparam int                    IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN        = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    typedef struct packed {
        logic                  ok;
        logic [IDX_W-1:0]      idx;
    } dec_t;

    typedef struct packed {
        logic                  aw_held;
        logic                  w_held;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } wreq_t;

    // Extra top bit catches addresses below BASE_ADDR as a borrow.
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] off;
        dec_t                d;
        off   = {1'b0, a} - {1'b0, BASE_ADDR};
        d.ok  = !off[ADDR_WIDTH] && (off[ADDR_WIDTH-1:0] < SPAN);
        d.idx = off[IDX_W+1:2];
        return d;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wire unused_prot = &{1'b0, s_axi_awprot, s_axi_arprot};

    w_state_t              w_state_q, w_state_d;
    wreq_t                 wreq_q, wreq_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
    logic                  mem_we;
    dec_t                  wdec;

    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
    dec_t                  rdec;

    // Commit happens one edge after both channels are held, so readies never
    // depend on the current valids.
    always_comb begin
        w_state_d = w_state_q;
        wreq_d    = wreq_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        wdec      = decode(wreq_q.addr);
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    wreq_d.aw_held = 1'b1;
                    wreq_d.addr    = s_axi_awaddr;
                end
                if (s_axi_wvalid && wready_q) begin
                    wreq_d.w_held = 1'b1;
                    wreq_d.data   = s_axi_wdata;
                    wreq_d.strb   = s_axi_wstrb;
                end
                if (wreq_q.aw_held && wreq_q.w_held) begin
                    mem_we    = wdec.ok;
                    bvalid_d  = 1'b1;
                    bresp_d   = wdec.ok ? RESP_OKAY : RESP_SLVERR;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d       = 1'b0;
                    wreq_d.aw_held = 1'b0;
                    wreq_d.w_held  = 1'b0;
                    w_state_d      = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !wreq_d.aw_held;
        wready_d  = (w_state_d == W_IDLE) && !wreq_d.w_held;
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rdec      = decode(s_axi_araddr);
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rdec.ok ? mem[rdec.idx] : '0;
                    rresp_d   = rdec.ok ? RESP_OKAY : RESP_SLVERR;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            wreq_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            wreq_q    <= wreq_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // No reset on the array: contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wreq_q.strb[b]) mem[wdec.idx][8*b +: 8] <= wreq_q.data[8*b +: 8];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: reset, reads, writes, strobes, errors,
// backpressure, collisions and reset during a pending response.
module tb_axi_lite_sram_slave;
    logic        aclk, aresetn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    int checks = 0;
    int errors = 0;

    axi_lite_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        s_axi_araddr = a;
        n = 0;
        while (!s_axi_arready && n < 20) begin step(); n++; end
        if (!s_axi_arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h arready=%b required 1", a, s_axi_arready);
            d = 'x; r = 'x;
            return;
        end
        s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin step(); n++; end
        if (!s_axi_rvalid) begin
            checks++; errors++;
            $display("FAIL r_timeout addr=%h rvalid=%b required 1", a, s_axi_rvalid);
            d = 'x; r = 'x;
            return;
        end
        d = s_axi_rdata;
        r = s_axi_rresp;
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
        logic aw_done, w_done, aw_go, w_go;
        int   n;
        aw_done = 1'b0; w_done = 1'b0;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            s_axi_awvalid = !aw_done && cyc >= aw_dly;
            s_axi_wvalid  = !w_done && cyc >= w_dly;
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go  = s_axi_wvalid && s_axi_wready;
            step();
            if (aw_go) aw_done = 1'b1;
            if (w_go)  w_done  = 1'b1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL aw_w_timeout addr=%h aw_done=%b w_done=%b required 1/1", a, aw_done, w_done);
            resp = 'x;
            return;
        end
        n = 0;
        while (!s_axi_bvalid && n < 20) begin step(); n++; end
        if (!s_axi_bvalid) begin
            checks++; errors++;
            $display("FAIL b_timeout addr=%h bvalid=%b required 1", a, s_axi_bvalid);
            resp = 'x;
            return;
        end
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             s_axi_bresp, s_axi_rresp, s_axi_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs aw/w/ar rdy=%b%b%b bv=%b rv=%b rdata=%h required all 0",
                     s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge got %b required 000", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        step();
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_release got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_read_preload();
        s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hDEAD_BEEF || s_axi_rresp !== 2'b00) begin
            errors++;
            $display("FAIL preload_read rv=%b rdata=%h rresp=%b required 1 deadbeef 00",
                     s_axi_rvalid, s_axi_rdata, s_axi_rresp);
        end
        checks++;
        if (s_axi_arready !== 1'b0) begin
            errors++; $display("FAIL arready_in_rdata got %b required 0", s_axi_arready);
        end
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL read_return_idle rv=%b arready=%b required 0 1", s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_write_split();
        logic [1:0]  r;
        logic [31:0] d;
        do_write(32'h10, 32'h1122_3344, 4'hF, 0, 3, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL split_aw_first_bresp got %b required 00", r); end
        do_read(32'h10, d, r);
        checks++;
        if (d !== 32'h1122_3344 || r !== 2'b00) begin
            errors++; $display("FAIL split_aw_first_read got %h/%b required 11223344/00", d, r);
        end
        do_write(32'h18, 32'h0A0B_0C0D, 4'hF, 2, 0, r);
        do_read(32'h18, d, r);
        checks++;
        if (d !== 32'h0A0B_0C0D || r !== 2'b00) begin
            errors++; $display("FAIL split_w_first_read got %h/%b required 0a0b0c0d/00", d, r);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        dut.mem[1] = 32'hFFFF_FFFF;
        do_write(32'h4, 32'h0, 4'b0101, 0, 0, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL strobe_bresp got %b required 00", r); end
        do_read(32'h4, d, r);
        checks++;
        if (d !== 32'hFF00_FF00) begin errors++; $display("FAIL strobe_read got %h required ff00ff00", d); end
        do_write(32'h4, 32'h1234_5678, 4'b0000, 0, 0, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL zero_strb_bresp got %b required 00", r); end
        do_read(32'h7, d, r);
        checks++;
        if (d !== 32'hFF00_FF00 || r !== 2'b00) begin
            errors++; $display("FAIL zero_strb_unaligned_read got %h/%b required ff00ff00/00", d, r);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  r;
        logic [31:0] d;
        do_write(32'h1000, 32'hCAFE_F00D, 4'hF, 0, 0, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b required 10", r); end
        checks++;
        if (dut.mem[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL oor_no_alias mem0=%h required deadbeef", dut.mem[0]);
        end
        do_read(32'h1000, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL oor_read got %h/%b required 00000000/10", d, r);
        end
        dut.mem[1023] = 32'h0BAD_F00D;
        do_read(32'hFFC, d, r);
        checks++;
        if (d !== 32'h0BAD_F00D || r !== 2'b00) begin
            errors++; $display("FAIL last_word_read got %h/%b required 0badf00d/00", d, r);
        end
    endtask

    task automatic test_collision();
        logic [1:0]  r;
        logic [31:0] d;
        dut.mem[5] = 32'hAAAA_5555;
        s_axi_awaddr = 32'h14; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early got %b required 0", s_axi_bvalid); end
        s_axi_araddr = 32'h14; s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            errors++; $display("FAIL write_latency bv=%b bresp=%b required 1 00", s_axi_bvalid, s_axi_bresp);
        end
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hAAAA_5555) begin
            errors++; $display("FAIL collision_old_data rv=%b rdata=%h required 1 aaaa5555", s_axi_rvalid, s_axi_rdata);
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        step();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL after_collision rdy/bv/rv=%b required 11100",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
        end
        do_read(32'h14, d, r);
        checks++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL collision_new_data got %h required 12345678", d); end
    endtask

    task automatic test_backpressure();
        s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
        step();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hDEAD_BEEF || s_axi_arready !== 1'b0) begin
                errors++;
                $display("FAIL r_hold cyc=%0d rv=%b rdata=%h arready=%b required 1 deadbeef 0",
                         i, s_axi_rvalid, s_axi_rdata, s_axi_arready);
            end
            step();
        end
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        s_axi_awaddr = 32'h1C; s_axi_wdata = 32'h7777_0000; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        step();
        s_axi_awaddr = 32'h0; s_axi_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cyc=%0d bv=%b bresp=%b awr=%b wr=%b required 1 00 0 0",
                         i, s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready);
            end
            step();
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        checks++;
        if (dut.mem[7] !== 32'h7777_0000 || dut.mem[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL blocked_aw_w mem7=%h mem0=%h required 77770000 deadbeef", dut.mem[7], dut.mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        s_axi_araddr = 32'h10; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        step();
        s_axi_araddr = 32'h4;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h1122_3344) begin
            errors++; $display("FAIL b2b_first rv=%b rdata=%h required 1 11223344", s_axi_rvalid, s_axi_rdata);
        end
        step();
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++; $display("FAIL b2b_gap rv=%b arready=%b required 0 1", s_axi_rvalid, s_axi_arready);
        end
        step();
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hFF00_FF00) begin
            errors++; $display("FAIL b2b_second rv=%b rdata=%h required 1 ff00ff00", s_axi_rvalid, s_axi_rdata);
        end
        step();
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset_inflight();
        logic [1:0]  r;
        logic [31:0] d;
        s_axi_awaddr = 32'h20; s_axi_wdata = 32'h5A5A_5A5A; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        step();
        checks++;
        if (s_axi_bvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_bvalid got %b required 1", s_axi_bvalid); end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset bv/rdy=%b required 0000", {s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready});
        end
        step();
        step();
        aresetn = 1'b1;
        step();
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid} !== 4'b1110) begin
            errors++;
            $display("FAIL post_reset rdy/bv=%b required 1110", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid});
        end
        do_read(32'h20, d, r);
        checks++;
        if (d !== 32'h5A5A_5A5A || r !== 2'b00) begin
            errors++; $display("FAIL mem_retained got %h/%b required 5a5a5a5a/00", d, r);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = '0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = '0;
        s_axi_rready = 1'b0;
        dut.mem[0] = 32'hDEAD_BEEF;
        test_reset();
        test_read_preload();
        test_write_split();
        test_strobe();
        test_out_of_range();
        test_collision();
        test_backpressure();
        test_back_to_back();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
